// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment codes and shared constants for the seven-segment scan driver
package seg7_pkg;
    localparam int SEG_W = 7;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Segment order is {a,b,c,d,e,f,g}; a is the MSB.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1110011;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - value/control inputs and scanned panel outputs of the display driver
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 3
);
    import seg7_pkg::*;

    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [SEG_W-1:0]        seg_out;
    logic [NUM_DIGITS-1:0]   dig_en;
    logic                    frame_done;

    modport master (
        output digits_in, load, blank_lz, blink_mask,
        input  seg_out, dig_en, frame_done
    );

    modport slave (
        input  digits_in, load, blank_lz, blink_mask,
        output seg_out, dig_en, frame_done
    );
endinterface

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - combinational BCD to seven-segment encoder, dash for codes above 9
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [3:0]       bcd,
    output logic [SEG_W-1:0] seg
);
    always_comb begin
        seg = SEG_DASH;
        if (bcd <= BCD_MAX) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                default: seg = SEG_9;
            endcase
        end
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scan driver; SEG7_BLINK_EN enables per-digit blink
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 64
) (
    input  logic clk,
    input  logic rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [SW-1:0]         slot;
    logic [DW-1:0]         pending;
    logic [DW-1:0]         display;
    logic                  term;
    logic                  wrap;
    logic [SW-1:0]         next_slot;
    logic [DW-1:0]         src_val;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [3:0]            cur_bcd;
    logic [SEG_W-1:0]      enc_seg;
    logic [SEG_W-1:0]      next_seg;
    logic                  blink_off;

    // Outputs are computed for the slot that follows this edge, so at a frame
    // wrap the incoming value (and phase) is used, keeping each frame coherent.
    always_comb begin
        term = (presc == PRESC_LAST);
        wrap = term && (slot == SLOT_LAST);
        if (!term)
            next_slot = slot;
        else if (slot == SLOT_LAST)
            next_slot = '0;
        else
            next_slot = slot + 1'b1;
        src_val = wrap ? (bus.load ? bus.digits_in : pending) : display;
    end

    always_comb begin
        logic suppress;
        suppress = bus.blank_lz;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (suppress && (src_val[4*i +: 4] == 4'd0))
                lz_blank[i] = 1'b1;
            else
                suppress = 1'b0;
        end
    end

    assign cur_bcd = src_val[{next_slot, 2'b00} +: 4];

    seg7_encode u_encode (
        .bcd (cur_bcd),
        .seg (enc_seg)
    );

`ifdef SEG7_BLINK_EN
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [FW-1:0] fcnt;
    logic          phase;
    logic          next_phase;

    always_comb begin
        next_phase = (wrap && (fcnt == FRAME_LAST)) ? ~phase : phase;
        blink_off  = next_phase && bus.blink_mask[next_slot];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            fcnt  <= (fcnt == FRAME_LAST) ? '0 : fcnt + 1'b1;
            phase <= next_phase;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^{bus.blink_mask, BLINK_DIV > 0};
    assign blink_off    = 1'b0;
`endif

    assign next_seg = (lz_blank[next_slot] || blink_off) ? SEG_BLANK : enc_seg;

    // dig_en drops in the last prescaler cycle of each slot to hide segment changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc          <= '0;
            slot           <= '0;
            pending        <= '0;
            display        <= '0;
            bus.seg_out    <= SEG_BLANK;
            bus.dig_en     <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            presc <= term ? '0 : presc + 1'b1;
            slot  <= next_slot;
            if (bus.load)
                pending <= bus.digits_in;
            if (wrap)
                display <= src_val;
            bus.seg_out    <= next_seg;
            bus.dig_en     <= term ? '0 : (NUM_DIGITS'(1) << next_slot);
            bus.frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver against a frame-level reference model
module tb_seg7_scan_driver;
    localparam int N  = 3;
    localparam int S  = 4;
    localparam int B  = 2;
    localparam int FR = S * N;

    typedef struct packed {
        logic [6:0]   seg;
        logic [N-1:0] en;
        logic         fd;
    } exp_t;

    localparam logic [6:0] SEGTAB [0:9] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011
    };

    logic clk;
    logic rst_n;
    seg7_scan_driver_if #(.NUM_DIGITS(N)) bus ();

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_DIV(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    logic [4*N-1:0] latest = '0;
    logic [4*N-1:0] fval   = '0;
    bit   started = 0;

    // Reference: edge k shows position k-1; a value loaded at or before edge
    // f*FR is the value of frame f; blink phase of frame f is (f/B) mod 2.
    always @(posedge clk) begin
        exp_t e;
        int q, p, sl, q2, sl2, f2, hi, d;
        bit ph;
        e = '0;
        if (!rst_n) begin
            k = 0;
            latest = '0;
            fval = '0;
        end else begin
            k++;
            if (bus.load) latest = bus.digits_in;
            if (k % FR == 0) fval = latest;
            q  = k - 1;
            p  = q % S;
            sl = (q / S) % N;
            e.fd = (p == S - 1) && (sl == N - 1);
            e.en = (p == S - 1) ? '0 : (N'(1) << sl);
            q2  = (p == S - 1) ? k : q;
            sl2 = (q2 / S) % N;
            f2  = q2 / FR;
`ifdef SEG7_BLINK_EN
            ph = ((f2 / B) % 2) == 1;
`else
            ph = 0;
`endif
            hi = 0;
            for (int i = 0; i < N; i++)
                if (((fval >> (4 * i)) & 4'hF) != 0) hi = i;
            d = int'((fval >> (4 * sl2)) & 4'hF);
            if (bus.blank_lz && sl2 > hi)
                e.seg = 7'b0000000;
            else if (ph && bus.blink_mask[sl2])
                e.seg = 7'b0000000;
            else if (d < 10)
                e.seg = SEGTAB[d];
            else
                e.seg = 7'b0000001;
        end
        expq.push_back(e);
        started = 1;
    end

    always @(negedge clk) begin
        exp_t e, a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = '{seg: bus.seg_out, en: bus.dig_en, fd: bus.frame_done};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL out t=%0t k=%0d seg=%b en=%b fd=%b expected seg=%b en=%b fd=%b",
                         $time, k, a.seg, a.en, a.fd, e.seg, e.en, e.fd);
            end
        end else if (started) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty t=%0t actual=0 required=1 entries", $time);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [4*N-1:0] v);
        bus.digits_in = v;
        bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        bus.digits_in = 12'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.digits_in  = '0;
        bus.load       = 1'b0;
        bus.blank_lz   = 1'b0;
        bus.blink_mask = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(30);

        idle(5);
        do_load(12'h259);
        idle(30);

        bus.blank_lz = 1'b1;
        do_load(12'h005);
        idle(30);
        do_load(12'h000);
        idle(30);
        do_load(12'h0A3);
        idle(30);

        bus.blank_lz = 1'b0;
        bus.blink_mask = 3'b100;
        do_load(12'h123);
        idle(FR * 8);

        bus.blink_mask = '0;
        for (int i = 0; i < FR && ((k / S) % N) != 1; i++) @(negedge clk);
        do_load(12'h777);
        for (int i = 0; i < FR && ((k / S) % N) != 2; i++) @(negedge clk);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(30);

        for (int i = 0; i < 150; i++) begin
            bus.blank_lz   = 1'($urandom);
            bus.blink_mask = 3'($urandom);
            do_load(12'($urandom));
            idle($urandom_range(0, 14));
        end

        // Loads on consecutive cycles across a frame boundary.
        for (int i = 0; i < 20; i++) do_load(12'($urandom));
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed seven-segment display driver for the microwave timer front panel, parametrised in digit count. It captures a packed BCD word, shows one digit per scan slot via a shared segment bus and one-hot digit enables, and adds leading-zero suppression, invalid-code indication and per-digit blink. It replaces the per-digit static decoders between the countdown counter and the panel pins.

## Interface
- NUM_DIGITS, 3: digits driven; digit 0 is least significant (seconds ones).
- SCAN_DIV, 1000: clk cycles per digit slot, ≥2.
- BLINK_DIV, 64: full scan frames per blink half-period, ≥1.
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- digits_in  in  4*NUM_DIGITS  packed BCD; digit i at [4i+3:4i].
- load  in  1  one-cycle strobe; captures digits_in.
- blank_lz  in  1  1 = leading-zero suppression enabled.
- blink_mask  in  NUM_DIGITS  1 = digit i blinks.
- seg_out  out  7  segments {a,b,c,d,e,f,g}, a = MSB, active-high.
- dig_en  out  NUM_DIGITS  one-hot digit enable, active-high.
- frame_done  out  1  one-cycle pulse at the end of each full scan frame.

## Operation
- Segment codes: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011; BCD 10-15 → dash 0000001; blank 0000000.
- load writes pending register; pending copies to display register at each frame boundary (slot index wraps to 0). load coinciding with the boundary: digits_in goes straight to the display register. Every frame shows one coherent value.
- Prescaler counts 0..SCAN_DIV-1; at terminal count slot index advances, NUM_DIGITS-1 → 0 wraps, and frame_done pulses.
- Leading-zero suppression: with blank_lz=1, digits from NUM_DIGITS-1 downward that equal 0 are blanked until the first non-zero digit. Digit 0 is never suppressed. An invalid code stops suppression.
- Blink phase toggles every BLINK_DIV frames. While phase=1, digits with blink_mask[i]=1 output blank. dig_en is unaffected.
- Anti-ghosting: dig_en is all-zero during the last prescaler cycle of every slot. seg_out is updated for the next digit in that cycle.
- Scan states: RUN only; reset is the sole way to re-enter slot 0.

## Timing
- Reset values: prescaler 0, slot 0, pending/display 0, blink phase 0, frame counter 0, seg_out 0000000, dig_en 0, frame_done 0.
- First cycle after rst_n rises: dig_en=...001 and seg_out=1111110 (digit 0 shows 0).
- seg_out, dig_en and frame_done are registered, with one cycle of latency from the slot index.
- load to first visible digit: up to one frame plus one cycle.
- Reset asserted mid-frame: all state returns to reset values on that edge. Pending loads are discarded.
- Changes on blink_mask and blank_lz are sampled every cycle and take effect on the next registered output.

## Configuration
- SEG7_BLINK_EN defined: blink phase, frame counter and blink_mask gating are compiled in.
- Without it: the blink_mask port remains but is ignored, no frame counter exists, and BLINK_DIV is unused.

## Structure
- seg7_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - the segment-width localparam;
  - the BCD-max constant.
- Sub-module seg7_encode is the combinational 4-bit BCD → 7-segment encoder with the dash fallback, instantiated once on the muxed digit.

## Test plan
Use NUM_DIGITS=3, SCAN_DIV=4, BLINK_DIV=2, SEG7_BLINK_EN defined.
- Reset: hold rst_n=0 for 3 cycles, then release → seg_out=1111110, dig_en=001 on the first cycle. dig_en=000 on cycle 4. frame_done pulses on cycle 12.
- Load: load 0x259 mid-frame → the old value completes the frame. Next frame shows digit0=1110011, digit1=1011011, digit2=1101101.
- Leading-zero suppression: load 0x005 with blank_lz=1 → digits 2 and 1 are 0000000, digit 0 is 1011011. Load 0x000 → only digit 0 shows 1111110.
- Invalid code: load 0x0A3 → digit 1 shows 0000001 and digit 2 is blanked by blank_lz=1.
- Blink: blink_mask=100, value 0x123 → digit 2 shows 0110000 in frames 0-1, 0000000 in frames 2-3, then repeats. dig_en stays one-hot.
- Reset mid-operation: assert rst_n=0 during slot 2 of a frame with load pending → outputs return to 0, and the next frame shows 000.
